exc_commit_cp0: RTL and testbench

Memory-stage exception commit unit with the CP0 register file (Status, Cause, EPC, Count, Compare). It consumes the 32-bit exception-type word carried down the pipeline from decode through ID/EX and EX/MEM. It merges that word with pending interrupts and takes one exception or ERET per cycle. For the taken event it drives the pipeline flush and the redirect PC, and it updates CP0 state on the clock edge.

---
 rtl/exc_commit_cp0_if.sv | 28 ++
 rtl/exc_commit_cp0.sv | 151 +++++++++++++++
 tb/tb_exc_commit_cp0.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/exc_commit_cp0_if.sv
// rtl/exc_commit_cp0_if.sv - MEM-stage commit and CP0 access bundle for exc_commit_cp0
interface exc_commit_cp0_if;
    logic        valid_i;
    logic [31:0] excepttype_i;
    logic [31:0] pc_i;
    logic        in_delayslot_i;
    logic [4:0]  int_i;
    logic        cp0_we_i;
    logic [4:0]  cp0_waddr_i;
    logic [31:0] cp0_wdata_i;
    logic [4:0]  cp0_raddr_i;
    logic [31:0] cp0_rdata_o;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic        timer_int_o;

    modport master (
        output valid_i, excepttype_i, pc_i, in_delayslot_i, int_i,
        output cp0_we_i, cp0_waddr_i, cp0_wdata_i, cp0_raddr_i,
        input  cp0_rdata_o, flush_o, new_pc_o, timer_int_o
    );

    modport slave (
        input  valid_i, excepttype_i, pc_i, in_delayslot_i, int_i,
        input  cp0_we_i, cp0_waddr_i, cp0_wdata_i, cp0_raddr_i,
        output cp0_rdata_o, flush_o, new_pc_o, timer_int_o
    );
endinterface

// File: rtl/exc_commit_cp0.sv
// rtl/exc_commit_cp0.sv - MEM-stage exception/eret commit with Status, Cause, EPC, Count, Compare
module exc_commit_cp0 #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0380
) (
    input logic            clk,
    input logic            rst_n,
    exc_commit_cp0_if.slave bus
);
    localparam logic [4:0] ADDR_COUNT   = 5'd9;
    localparam logic [4:0] ADDR_COMPARE = 5'd11;
    localparam logic [4:0] ADDR_STATUS  = 5'd12;
    localparam logic [4:0] ADDR_CAUSE   = 5'd13;
    localparam logic [4:0] ADDR_EPC     = 5'd14;

    localparam logic [4:0] CODE_INT = 5'd0;
    localparam logic [4:0] CODE_SYS = 5'd8;
    localparam logic [4:0] CODE_RI  = 5'd10;

    logic [31:0] status;
    logic [31:0] epc;
    logic [31:0] count;
    logic [31:0] compare;
    logic        cause_bd;
    logic        cause_ip7;
    logic [4:0]  cause_ip_hw;
    logic [1:0]  cause_ip_sw;
    logic [4:0]  cause_exccode;

    logic [7:0]  cause_ip;
    logic [31:0] cause_word;
    logic        status_ie;
    logic        status_exl;
    logic [7:0]  status_im;

    logic        int_pend;
    logic        is_syscall;
    logic        is_invalid;
    logic        is_eret;
    logic        exc_take;
    logic        eret_take;
    logic        event_take;
    logic [4:0]  exc_code;
    logic        cp0_wr;
    logic        timer_hit;
    logic        raddr_impl;
    logic [31:0] rdata_sel;
    logic        unused_excepttype;

    assign cause_ip   = {cause_ip7, cause_ip_hw, cause_ip_sw};
    assign cause_word = {cause_bd, 15'b0, cause_ip, 1'b0, cause_exccode, 2'b00};
    assign status_ie  = status[0];
    assign status_exl = status[1];
    assign status_im  = status[15:8];

    assign is_syscall = bus.excepttype_i[8];
    assign is_invalid = bus.excepttype_i[9];
    assign is_eret    = bus.excepttype_i[12];
    assign unused_excepttype = ^{bus.excepttype_i[31:13], bus.excepttype_i[11:10],
                                 bus.excepttype_i[7:0]};

    // Interrupts are judged on registered IP, so a line change is seen one cycle later.
    assign int_pend   = status_ie & ~status_exl & (|(cause_ip & status_im));
    assign exc_take   = bus.valid_i & (int_pend | is_invalid | is_syscall);
    assign eret_take  = bus.valid_i & is_eret & ~exc_take;
    assign event_take = exc_take | eret_take;
    assign cp0_wr     = bus.valid_i & bus.cp0_we_i & ~event_take;
    assign timer_hit  = (count == compare) && (compare != 32'd0);

    always_comb begin
        exc_code = CODE_SYS;
        if (int_pend) begin
            exc_code = CODE_INT;
        end else if (is_invalid) begin
            exc_code = CODE_RI;
        end
    end

    always_comb begin
        raddr_impl = 1'b1;
        rdata_sel  = 32'd0;
        case (bus.cp0_raddr_i)
            ADDR_COUNT:   rdata_sel = count;
            ADDR_COMPARE: rdata_sel = compare;
            ADDR_STATUS:  rdata_sel = status;
            ADDR_CAUSE:   rdata_sel = cause_word;
            ADDR_EPC:     rdata_sel = epc;
            default:      raddr_impl = 1'b0;
        endcase
        if (raddr_impl && cp0_wr && (bus.cp0_waddr_i == bus.cp0_raddr_i)) begin
            rdata_sel = bus.cp0_wdata_i;
        end
    end

    assign bus.cp0_rdata_o = rst_n ? rdata_sel : 32'd0;
    assign bus.flush_o     = rst_n & event_take;
    assign bus.new_pc_o    = !rst_n   ? 32'd0 :
                             exc_take  ? EXC_VECTOR :
                             eret_take ? epc : 32'd0;
    assign bus.timer_int_o = cause_ip7;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            status        <= 32'd0;
            epc           <= 32'd0;
            count         <= 32'd0;
            compare       <= 32'd0;
            cause_bd      <= 1'b0;
            cause_ip7     <= 1'b0;
            cause_ip_hw   <= 5'd0;
            cause_ip_sw   <= 2'd0;
            cause_exccode <= 5'd0;
        end else begin
            cause_ip_hw <= bus.int_i;

            if (cp0_wr && bus.cp0_waddr_i == ADDR_COUNT) begin
                count <= bus.cp0_wdata_i;
            end else begin
                count <= count + 32'd1;
            end

            // A Compare write acknowledges the timer even if it matches this cycle.
            if (cp0_wr && bus.cp0_waddr_i == ADDR_COMPARE) begin
                compare   <= bus.cp0_wdata_i;
                cause_ip7 <= 1'b0;
            end else if (timer_hit) begin
                cause_ip7 <= 1'b1;
            end

            if (cp0_wr) begin
                case (bus.cp0_waddr_i)
                    ADDR_STATUS: status      <= bus.cp0_wdata_i;
                    ADDR_CAUSE:  cause_ip_sw <= bus.cp0_wdata_i[9:8];
                    ADDR_EPC:    epc         <= bus.cp0_wdata_i;
                    default:     ;
                endcase
            end

            // Nested exceptions keep the first EPC/BD so the outer handler can return.
            if (exc_take) begin
                cause_exccode <= exc_code;
                if (!status_exl) begin
                    epc      <= bus.in_delayslot_i ? bus.pc_i - 32'd4 : bus.pc_i;
                    cause_bd <= bus.in_delayslot_i;
                end
                status[1] <= 1'b1;
            end else if (eret_take) begin
                status[1] <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_exc_commit_cp0.sv
// tb/tb_exc_commit_cp0.sv - directed and randomized checks of exc_commit_cp0 against a CP0 model
module tb_exc_commit_cp0;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    exc_commit_cp0_if bus ();

    exc_commit_cp0 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] m_status, m_cause, m_epc, m_count, m_compare;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return m_status;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    // One cycle: drive at the falling edge, check combinational outputs, advance the model at the rising edge.
    task automatic step(input logic v, input logic [31:0] et, input logic [31:0] pc,
                        input logic ds, input logic [4:0] irq, input logic we,
                        input logic [4:0] wa, input logic [31:0] wd, input logic [4:0] ra);
        logic        int_pend, exc, eret, wr, hit, impl;
        logic [4:0]  code;
        logic [31:0] exp_rd, n_cause, n_count;
        bus.valid_i = v;
        bus.excepttype_i = et;
        bus.pc_i = pc;
        bus.in_delayslot_i = ds;
        bus.int_i = irq;
        bus.cp0_we_i = we;
        bus.cp0_waddr_i = wa;
        bus.cp0_wdata_i = wd;
        bus.cp0_raddr_i = ra;
        #1;
        if (!rst_n) begin
            chk("rst_flush", {31'b0, bus.flush_o}, 32'd0);
            chk("rst_new_pc", bus.new_pc_o, 32'd0);
            chk("rst_rdata", bus.cp0_rdata_o, 32'd0);
            @(posedge clk);
            m_status = 0; m_cause = 0; m_epc = 0; m_count = 0; m_compare = 0;
        end else begin
            int_pend = m_status[0] && !m_status[1] && ((m_cause[15:8] & m_status[15:8]) != 8'd0);
            exc  = v && (int_pend || et[9] || et[8]);
            eret = v && et[12] && !exc;
            code = int_pend ? 5'd0 : (et[9] ? 5'd10 : 5'd8);
            wr   = v && we && !exc && !eret;
            impl = (ra == 5'd9) || (ra == 5'd11) || (ra == 5'd12) || (ra == 5'd13) || (ra == 5'd14);
            exp_rd = !impl ? 32'd0 : ((wr && wa == ra) ? wd : m_read(ra));
            chk("flush", {31'b0, bus.flush_o}, {31'b0, exc || eret});
            if (exc || eret) chk("new_pc", bus.new_pc_o, exc ? 32'h380 : m_epc);
            chk("rdata", bus.cp0_rdata_o, exp_rd);
            chk("timer_int", {31'b0, bus.timer_int_o}, {31'b0, m_cause[15]});
            @(posedge clk);
            hit = (m_count == m_compare) && (m_compare != 0);
            n_count = (wr && wa == 5'd9) ? wd : m_count + 1;
            n_cause = m_cause;
            n_cause[14:10] = irq;
            if (hit) n_cause[15] = 1'b1;
            if (wr && wa == 5'd11) begin n_cause[15] = 1'b0; m_compare = wd; end
            if (wr && wa == 5'd13) n_cause[9:8] = wd[9:8];
            if (wr && wa == 5'd12) m_status = wd;
            if (wr && wa == 5'd14) m_epc = wd;
            if (exc) begin
                n_cause[6:2] = code;
                if (!m_status[1]) begin
                    m_epc = ds ? pc - 32'd4 : pc;
                    n_cause[31] = ds;
                end
                m_status[1] = 1'b1;
            end
            if (eret) m_status[1] = 1'b0;
            m_cause = n_cause;
            m_count = n_count;
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic [4:0] ra);
        step(1'b1, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, ra);
    endtask

    task automatic mtc0(input logic [4:0] wa, input logic [31:0] wd);
        step(1'b1, 32'd0, 32'd0, 1'b0, 5'd0, 1'b1, wa, wd, wa);
    endtask

    task automatic peek(input string tag, input logic [4:0] ra, input logic [31:0] exp);
        bus.valid_i = 1'b0;
        bus.cp0_we_i = 1'b0;
        bus.cp0_raddr_i = ra;
        #1;
        chk(tag, bus.cp0_rdata_o, exp);
    endtask

    initial begin
        logic        v, we, ds;
        logic [31:0] et, wd, pc;
        logic [4:0]  irq, wa, ra;
        logic [4:0]  addrs [7];
        addrs = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd10};
        m_status = 0; m_cause = 0; m_epc = 0; m_count = 0; m_compare = 0;

        @(negedge clk);
        step(1'b1, 32'h100, 32'h1000, 1'b0, 5'd0, 1'b1, 5'd14, 32'h55, 5'd14);
        step(1'b1, 32'h100, 32'h1000, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd12);
        rst_n = 1'b1;

        step(1'b1, 32'h100, 32'h1000, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd14);
        peek("syscall_epc", 5'd14, 32'h1000);
        peek("syscall_cause", 5'd13, 32'h0000_0020);
        peek("syscall_status", 5'd12, 32'h0000_0002);

        step(1'b1, 32'h1000, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd12);
        peek("eret_status", 5'd12, 32'h0);

        step(1'b1, 32'h200, 32'h2004, 1'b1, 5'd0, 1'b0, 5'd0, 32'd0, 5'd14);
        peek("ds_epc", 5'd14, 32'h2000);
        peek("ds_cause", 5'd13, 32'h8000_0028);
        step(1'b1, 32'h1000, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd14);

        step(1'b1, 32'h100, 32'h3000, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd14);
        step(1'b1, 32'h200, 32'h3100, 1'b1, 5'd0, 1'b0, 5'd0, 32'd0, 5'd14);
        peek("b2b_epc", 5'd14, 32'h3000);
        peek("b2b_cause", 5'd13, 32'h0000_0028);
        step(1'b1, 32'h1000, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd14);

        step(1'b1, 32'h1100, 32'h3200, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd12);
        peek("eret_with_exc_status", 5'd12, 32'h2);
        step(1'b1, 32'h1000, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd12);

        mtc0(5'd12, 32'h0000_0401);
        step(1'b1, 32'h0, 32'h0, 1'b0, 5'd1, 1'b0, 5'd0, 32'd0, 5'd13);
        step(1'b1, 32'h100, 32'h4000, 1'b0, 5'd1, 1'b0, 5'd0, 32'd0, 5'd13);
        peek("int_cause", 5'd13, 32'h0000_0400);
        peek("int_epc", 5'd14, 32'h4000);
        step(1'b1, 32'h1000, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd13);
        mtc0(5'd12, 32'h0);

        mtc0(5'd14, 32'h0000_ABCD);
        peek("bypass_epc", 5'd14, 32'h0000_ABCD);
        step(1'b1, 32'h100, 32'h5000, 1'b0, 5'd0, 1'b1, 5'd14, 32'h1234, 5'd14);
        peek("suppressed_epc", 5'd14, 32'h5000);
        step(1'b1, 32'h1000, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd14);

        rst_n = 1'b0;
        idle(5'd9);
        rst_n = 1'b1;
        idle(5'd9);
        mtc0(5'd11, 32'd5);
        for (int i = 0; i < 5; i++) idle(5'd13);
        peek("timer_set", 5'd13, 32'h0000_8000);
        chk("timer_int_set", {31'b0, bus.timer_int_o}, 32'd1);
        mtc0(5'd11, 32'd1000);
        chk("timer_int_clr", {31'b0, bus.timer_int_o}, 32'd0);

        mtc0(5'd9, 32'hFFFF_FFFF);
        peek("count_preload", 5'd9, 32'hFFFF_FFFF);
        idle(5'd9);
        peek("count_wrap", 5'd9, 32'h0);

        step(1'b1, 32'h100, 32'h6000, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd14);
        rst_n = 1'b0;
        step(1'b1, 32'h100, 32'h7000, 1'b0, 5'd0, 1'b1, 5'd14, 32'h99, 5'd14);
        rst_n = 1'b1;
        peek("rst_mid_epc", 5'd14, 32'h0);
        peek("rst_mid_status", 5'd12, 32'h0);

        for (int n = 0; n < 600; n++) begin
            v  = ($urandom_range(0, 9) != 0);
            et = $urandom & ~32'h0000_1300;
            if ($urandom_range(0, 9) == 0) et[8] = 1'b1;
            if ($urandom_range(0, 11) == 0) et[9] = 1'b1;
            if ($urandom_range(0, 5) == 0) et[12] = 1'b1;
            pc  = $urandom & 32'hFFFF_FFFC;
            ds  = $urandom_range(0, 1) == 1;
            irq = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
            we  = $urandom_range(0, 2) == 0;
            wa  = addrs[$urandom_range(0, 6)];
            case (wa)
                5'd11:   wd = m_count + 32'($urandom_range(1, 8));
                5'd12:   wd = $urandom & 32'h0000_FF03;
                default: wd = $urandom;
            endcase
            ra = addrs[$urandom_range(0, 6)];
            if ($urandom_range(0, 3) == 0) ra = wa;
            step(v, et, pc, ds, irq, we, wa, wd, ra);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
